// File: rtl/serial_deserializer_if.sv
// Bundle of serial input, flush control and parallel valid/ready output
// for serial_deserializer. The link side drives master; the converter takes slave.
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             din_serial;
  logic             din_valid;
  logic             din_flush;
  logic [WIDTH-1:0] dout_parallel;
  logic [CNT_W-1:0] dout_count;
  logic             dout_valid;
  logic             dout_ready;
  logic             overflow;

  modport master (
    output din_serial, din_valid, din_flush, dout_ready,
    input  dout_parallel, dout_count, dout_valid, overflow
  );

  modport slave (
    input  din_serial, din_valid, din_flush, dout_ready,
    output dout_parallel, dout_count, dout_valid, overflow
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: gathers WIDTH qualified bits (or a flushed
// partial word) into a one-entry valid/ready output register.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_deserializer_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] nbits;
  logic             complete;
  logic             emit;
  logic             can_load;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    sreg_nxt = sreg;
    if (bus.din_valid) begin
      sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], bus.din_serial}
                           : {bus.din_serial, sreg[WIDTH-1:1]};
    end
    nbits    = bcnt + CNT_W'(bus.din_valid);
    complete = bus.din_valid && (bcnt == CNT_W'(WIDTH - 1));
    emit     = complete || (bus.din_flush && (nbits != '0));
    can_load = !bus.dout_valid || bus.dout_ready;

    // LSB-first bits pile up at the top; a partial word must be right-aligned.
    word = sreg_nxt;
    if (!MSB_FIRST) begin
      word = sreg_nxt >> (CNT_W'(WIDTH) - nbits);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg              <= '0;
      bcnt              <= '0;
      bus.dout_parallel <= '0;
      bus.dout_count    <= '0;
      bus.dout_valid    <= 1'b0;
      bus.overflow      <= 1'b0;
    end else begin
      bus.overflow <= emit && !can_load;

      // A dropped word still clears the assembly state.
      if (emit) begin
        sreg <= '0;
        bcnt <= '0;
      end else if (bus.din_valid) begin
        sreg <= sreg_nxt;
        bcnt <= bcnt + CNT_W'(1);
      end

      if (emit && can_load) begin
        bus.dout_parallel <= word;
        bus.dout_count    <= nbits;
        bus.dout_valid    <= 1'b1;
      end else if (bus.dout_ready) begin
        bus.dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_deserializer.sv
// Drives one bit stream into an MSB-first and an LSB-first converter and
// checks both against a bit-level model feeding a scoreboard queue.
module tb_serial_deserializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_deserializer_if #(.WIDTH(W)) bus_m ();
  serial_deserializer_if #(.WIDTH(W)) bus_l ();

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cnt;
  } word_t;

  word_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    mcnt  = 0;
  logic  mbits [W];
  bit    exp_valid = 1'b0;
  bit    exp_ovf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int cnt);
    check({tag, "_data_m"}, 32'(bus_m.dout_parallel), 32'(a));
    check({tag, "_data_l"}, 32'(bus_l.dout_parallel), 32'(b));
    check({tag, "_cnt_m"},  32'(bus_m.dout_count), cnt);
    check({tag, "_cnt_l"},  32'(bus_l.dout_count), cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_par"},   32'(bus_m.dout_parallel) | 32'(bus_l.dout_parallel), 0);
    check({tag, "_cnt"},   32'(bus_m.dout_count) | 32'(bus_l.dout_count), 0);
    check({tag, "_valid"}, {30'd0, bus_m.dout_valid, bus_l.dout_valid}, 0);
    check({tag, "_ovf"},   {30'd0, bus_m.overflow, bus_l.overflow}, 0);
  endtask

  // One clock: drive inputs, check current outputs, advance model, clock.
  task automatic drive(input logic din, input logic v, input logic f, input logic rdy);
    word_t e;
    bit    done;
    bit    ovf_nxt;
    bus_m.din_serial = din; bus_m.din_valid = v; bus_m.din_flush = f; bus_m.dout_ready = rdy;
    bus_l.din_serial = din; bus_l.din_valid = v; bus_l.din_flush = f; bus_l.dout_ready = rdy;

    check("valid_m", 32'(bus_m.dout_valid), 32'(exp_valid));
    check("valid_l", 32'(bus_l.dout_valid), 32'(exp_valid));
    check("ovf_m",   32'(bus_m.overflow),   32'(exp_ovf));
    check("ovf_l",   32'(bus_l.overflow),   32'(exp_ovf));

    if (exp_valid && rdy && sb.size() > 0) begin
      e = sb.pop_front();
      check_out("sb", e.a, e.b, e.cnt);
    end

    if (v) begin
      mbits[mcnt] = din;
      mcnt++;
    end
    done    = (mcnt == W) || (f && mcnt > 0);
    ovf_nxt = 1'b0;
    if (done) begin
      e.a = '0; e.b = '0; e.cnt = mcnt;
      for (int i = 0; i < mcnt; i++) begin
        e.a    = {e.a[W-2:0], mbits[i]};
        e.b[i] = mbits[i];
      end
      mcnt = 0;
      if (!exp_valid || rdy) begin
        sb.push_back(e);
        exp_valid = 1'b1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    exp_ovf = ovf_nxt;

    @(posedge clk);
    #1;
  endtask

  // Bits go out from bit n-1 down to bit 0 of v.
  task automatic send_bits(input logic [31:0] v, input int n, input logic rdy, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gaps) drive(1'b0, 1'b0, 1'b0, rdy);
      drive(v[n-1-i], 1'b1, 1'b0, rdy);
    end
  endtask

  task automatic do_reset(input string tag);
    bus_m.din_valid = 1'b0; bus_m.din_flush = 1'b0; bus_m.din_serial = 1'b0; bus_m.dout_ready = 1'b0;
    bus_l.din_valid = 1'b0; bus_l.din_flush = 1'b0; bus_l.din_serial = 1'b0; bus_l.dout_ready = 1'b0;
    rst = 1'b1;
    #2;
    check_zero({tag, "_async"});
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    rst       = 1'b0;
    mcnt      = 0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    do_reset("rst0");

    // Consecutive bits, ready high
    send_bits(32'hB2, 8, 1'b1, 0);
    check_out("full", 8'hB2, 8'h4D, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("one_cycle_valid", 32'(bus_m.dout_valid), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Same word with random gaps
    send_bits(32'hB2, 8, 1'b1, 3);
    check_out("gaps", 8'hB2, 8'h4D, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush after three bits
    send_bits(32'b101, 3, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check_out("flush101", 8'h05, 8'h05, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b110, 3, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check_out("flush110", 8'h06, 8'h03, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush with nothing held
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("flush0_valid", {30'd0, bus_m.dout_valid, bus_l.dout_valid}, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush together with an accepted bit, and on the completing edge
    send_bits(32'b10, 2, 1'b1, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check_out("flush_bit", 8'h05, 8'h05, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b1001011, 7, 1'b1, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check_out("flush_full", 8'h96, 8'h69, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure and overflow
    send_bits(32'hA5, 8, 1'b0, 0);
    check_out("bp_first", 8'hA5, 8'hA5, 8);
    send_bits(32'h3C, 8, 1'b0, 0);
    check("ovf_pulse", {30'd0, bus_m.overflow, bus_l.overflow}, 32'b11);
    check_out("bp_held", 8'hA5, 8'hA5, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_gone", {30'd0, bus_m.overflow, bus_l.overflow}, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h0F, 8, 1'b1, 0);
    check_out("after_ovf", 8'h0F, 8'hF0, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Drain and load on the same edge
    send_bits(32'h12, 8, 1'b0, 0);
    send_bits(32'h1A, 7, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("swap_valid", {30'd0, bus_m.dout_valid, bus_l.dout_valid}, 32'b11);
    check("swap_ovf", {30'd0, bus_m.overflow, bus_l.overflow}, 0);
    check_out("swap", 8'h34, 8'h2C, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back words at full rate
    send_bits(32'hC35A, 16, 1'b1, 0);
    check_out("b2b", 8'h5A, 8'h5A, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial bits
    send_bits(32'b10110, 5, 1'b1, 0);
    do_reset("rst_mid");
    send_bits(32'hFF, 8, 1'b1, 0);
    check_out("post_rst", 8'hFF, 8'hFF, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Parametrised serial-to-parallel converter. Collects WIDTH serial bits qualified by `din_valid`, gaps between bits allowed, and delivers each word through a one-entry valid/ready output register. Supports MSB-first or LSB-first bit order, flushing a partial word, and an overflow indication when a completed word cannot be stored. Sits between a bit-serial link receiver and the byte/word-oriented datapath.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 = first received bit becomes the MSB of a full word; 0 = first received bit becomes bit 0.
- `CNT_W`, derived localparam = $clog2(WIDTH+1): width of bit counters; not overridable.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din_serial`  in  1  serial data bit.
- `din_valid`  in  1  `din_serial` is accepted on this edge.
- `din_flush`  in  1  terminate the current word and emit the bits held so far.
- `dout_parallel`  out  WIDTH  assembled word.
- `dout_count`  out  CNT_W  number of valid bits in `dout_parallel` (1..WIDTH).
- `dout_valid`  out  1  output register holds a word.
- `dout_ready`  in  1  consumer accepts the word when `dout_valid && dout_ready`.
- `overflow`  out  1  one-cycle pulse: a completed word was dropped.

## Operation
- Internal: assembly shift register `sreg[WIDTH-1:0]` and bit counter `bcnt` (0..WIDTH-1).
- Bit accept (`din_valid=1`): MSB_FIRST=1 shifts left with the new bit at LSB; MSB_FIRST=0 shifts right with the new bit at MSB. `bcnt` increments.
- Cycles with `din_valid=0` hold `sreg` and `bcnt`. Gaps do not abort the word.
- Word completion happens on the edge that accepts bit number WIDTH. The full word goes to the output register with `dout_count=WIDTH`, and `bcnt` returns to 0.
- Flush: on an edge with `din_flush=1`, the bits held plus any bit accepted on the same edge form a partial word of n bits, 1 ≤ n < WIDTH.
  - The partial word is emitted right-aligned in `dout_parallel[n-1:0]`, upper bits zero, `dout_count=n`.
  - MSB_FIRST=1: the first bit lands at `dout[n-1]`. MSB_FIRST=0: the first bit lands at `dout[0]`.
  - `bcnt` and `sreg` clear.
- Flush with n=0: no-op. Flush on the edge that completes a full word: treated as a normal full word.
- Output register:
  - Loads a new word when it is empty, or when it is being drained on the same edge (`dout_valid && dout_ready`).
  - Holds its value and `dout_valid` while `dout_ready=0`.
  - Drain without a new word: `dout_valid` clears; `dout_parallel` and `dout_count` keep their last value.
- Overflow: a completion or flush while `dout_valid=1 && dout_ready=0` drops the new word. The output register is unchanged, `overflow=1` for exactly one cycle, and the assembly state clears as for a normal completion.

## Timing
- Reset values: `dout_parallel=0`, `dout_count=0`, `dout_valid=0`, `overflow=0`, `sreg=0`, `bcnt=0`. Reset mid-word discards all partial bits. Reset with `dout_valid=1` discards the pending word.
- Latency: `dout_valid` rises in the cycle after the edge that accepts the last bit or samples the flush.
- Throughput: with `dout_ready` tied 1 and `din_valid` continuous, one word every WIDTH cycles. No bubble bits are lost; the first bit of word k+1 is accepted on the cycle after word k completes.
- `overflow` asserts in the same cycle `dout_valid` would have been reloaded, and deasserts the next cycle unless another drop occurs.
- `dout_ready` is ignored while `dout_valid=0`. Outputs are registered; no combinational path from `dout_ready` to any output.

## Test plan
- WIDTH=8, MSB_FIRST=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles, `dout_ready=1` -> `dout_parallel=0xB2`, `dout_count=8`, `dout_valid` high for one cycle, one cycle after the 8th bit.
- WIDTH=8, MSB_FIRST=0: same bits with random `din_valid` gaps of 0–3 cycles -> `0x4D`, `count=8`. Gaps do not corrupt the word.
- Flush: MSB_FIRST=1, bits 1,0,1 then `din_flush` -> `0x05`, `count=3`. MSB_FIRST=0, bits 1,1,0 then flush -> `0x03`, `count=3`. Flush with 0 bits -> no `dout_valid`.
- Backpressure/overflow: hold `dout_ready=0`, send two full words 0xA5 then 0x3C -> `dout_parallel` stays 0xA5, `overflow` pulses once at the second completion. Raise `dout_ready` -> 0xA5 drained, next word 0x0F received intact.
- Simultaneous drain and load: `dout_ready` rises on the same edge word 2 completes -> word 1 transferred, word 2 loaded, `dout_valid` stays 1, no overflow.
- Reset mid-word: assert `rst` after 5 bits, release, send 0xFF -> all outputs 0 during reset, then `0xFF` with `count=8`. No residue from the aborted word.
